// File: rtl/ahb3lite_timer.sv
// AHB3-Lite timer peripheral: prescaled 32-bit up-counter with compare, sticky match
// flag and level interrupt. Zero-wait-state OKAY for legal accesses, two-cycle ERROR otherwise.
module ahb3lite_timer #(
  parameter int g_haddr_size     = 32,
  parameter int g_hdata_size     = 32,
  parameter int g_prescale_width = 16
) (
  input  logic                    hclk_i,
  input  logic                    hreset_n_i,
  input  logic                    hsel_i,
  input  logic [g_haddr_size-1:0] haddr_i,
  input  logic [g_hdata_size-1:0] hwdata_i,
  output logic [g_hdata_size-1:0] hrdata_o,
  input  logic                    hwrite_i,
  input  logic [2:0]              hsize_i,
  input  logic [2:0]              hburst_i,
  input  logic [3:0]              hprot_i,
  input  logic [1:0]              htrans_i,
  output logic                    hreadyout_o,
  input  logic                    hready_i,
  output logic                    hresp_o,
  output logic                    irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam logic [g_prescale_width-1:0] PSC_ONE = 1;

  state_t                      state;
  logic                        data_write;
  logic [2:0]                  data_off;

  logic                        ctrl_en;
  logic                        ctrl_auto_reload;
  logic                        ctrl_irq_en;
  logic [g_prescale_width-1:0] prescale;
  logic [31:0]                 compare;
  logic [31:0]                 count;
  logic                        match;
  logic [g_prescale_width-1:0] psc_cnt;

  logic                        accept;
  logic [2:0]                  addr_off;
  logic                        addr_legal;
  logic                        bus_wr;
  logic                        wr_ctrl;
  logic                        wr_prescale;
  logic                        wr_compare;
  logic                        wr_count;
  logic                        wr_status;
  logic                        tick;
  logic                        hit;
  logic                        unused_inputs;

  assign unused_inputs = ^{hburst_i, hprot_i, htrans_i[0], haddr_i[1:0],
                           haddr_i[g_haddr_size-1:5]};

  assign accept     = hsel_i & hready_i & htrans_i[1];
  assign addr_off   = haddr_i[4:2];
  assign addr_legal = (hsize_i == 3'b010) & (addr_off <= OFF_STATUS);

  // Bus FSM; hreadyout/hresp are registered alongside the state they belong to.
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      state       <= ST_IDLE;
      data_write  <= 1'b0;
      data_off    <= '0;
      hreadyout_o <= 1'b1;
      hresp_o     <= 1'b0;
    end else begin
      case (state)
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_o <= 1'b1;
          hresp_o     <= 1'b1;
        end
        default: begin
          if (accept) begin
            data_write <= hwrite_i;
            data_off   <= addr_off;
            if (addr_legal) begin
              state       <= ST_DATA;
              hreadyout_o <= 1'b1;
              hresp_o     <= 1'b0;
            end else begin
              state       <= ST_ERR1;
              hreadyout_o <= 1'b0;
              hresp_o     <= 1'b1;
            end
          end else begin
            state       <= ST_IDLE;
            hreadyout_o <= 1'b1;
            hresp_o     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus_wr      = (state == ST_DATA) & data_write;
  assign wr_ctrl     = bus_wr & (data_off == OFF_CTRL);
  assign wr_prescale = bus_wr & (data_off == OFF_PRESCALE);
  assign wr_compare  = bus_wr & (data_off == OFF_COMPARE);
  assign wr_count    = bus_wr & (data_off == OFF_COUNT);
  assign wr_status   = bus_wr & (data_off == OFF_STATUS);

  assign tick = ctrl_en & (psc_cnt == prescale);
  assign hit  = tick & (count == compare);

  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      ctrl_en          <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      prescale         <= '0;
      compare          <= '0;
      count            <= '0;
      match            <= 1'b0;
      psc_cnt          <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en          <= hwdata_i[0];
        ctrl_auto_reload <= hwdata_i[1];
        ctrl_irq_en      <= hwdata_i[2];
      end
      if (wr_prescale) prescale <= hwdata_i[g_prescale_width-1:0];
      if (wr_compare)  compare  <= hwdata_i[31:0];

      // Prescaler restarts on a PRESCALE write or when the timer is switched off.
      if (wr_prescale | (wr_ctrl & ctrl_en & ~hwdata_i[0])) begin
        psc_cnt <= '0;
      end else if (ctrl_en) begin
        psc_cnt <= tick ? '0 : psc_cnt + PSC_ONE;
      end

      if (wr_count) begin
        count <= hwdata_i[31:0];
      end else if (tick) begin
        count <= (hit & ctrl_auto_reload) ? '0 : count + 32'd1;
      end

      if (hit) begin
        match <= 1'b1;
      end else if (wr_status & hwdata_i[0]) begin
        match <= 1'b0;
      end
    end
  end

  always_comb begin
    hrdata_o = '0;
    if ((state == ST_DATA) && !data_write) begin
      case (data_off)
        OFF_CTRL:     hrdata_o = {{(g_hdata_size-3){1'b0}}, ctrl_irq_en, ctrl_auto_reload, ctrl_en};
        OFF_PRESCALE: hrdata_o = g_hdata_size'(prescale);
        OFF_COMPARE:  hrdata_o = compare;
        OFF_COUNT:    hrdata_o = count;
        OFF_STATUS:   hrdata_o = {{(g_hdata_size-1){1'b0}}, match};
        default:      hrdata_o = '0;
      endcase
    end
  end

  assign irq_o = match & ctrl_irq_en;

endmodule

// File: tb/tb_ahb3lite_timer.sv
// Randomized bench for ahb3lite_timer against a transaction-level reference of the
// register map, timer rules and bus response sequence.
module tb_ahb3lite_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hreadyout;
  logic        hready;
  logic        hresp;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  assign hready = hreadyout;

  ahb3lite_timer #(
    .g_haddr_size    (32),
    .g_hdata_size    (32),
    .g_prescale_width(16)
  ) dut (
    .hclk_i     (clk),
    .hreset_n_i (rst_n),
    .hsel_i     (hsel),
    .haddr_i    (haddr),
    .hwdata_i   (hwdata),
    .hrdata_o   (hrdata),
    .hwrite_i   (hwrite),
    .hsize_i    (hsize),
    .hburst_i   (hburst),
    .hprot_i    (hprot),
    .htrans_i   (htrans),
    .hreadyout_o(hreadyout),
    .hready_i   (hready),
    .hresp_o    (hresp),
    .irq_o      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
  endtask

  // Reference model: register file by word offset plus the bus phase the spec names.
  typedef enum int {P_IDLE, P_DATA, P_ERR1, P_ERR2} phase_t;
  phase_t      ph;
  logic        m_wr;
  int          m_off;
  logic [31:0] m_reg [5];   // CTRL, PRESCALE, COMPARE, COUNT, STATUS
  int unsigned m_psc;

  function automatic void model_reset();
    ph    = P_IDLE;
    m_wr  = 1'b0;
    m_off = 0;
    for (int i = 0; i < 5; i++) m_reg[i] = '0;
    m_psc = 0;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (ph == P_DATA && !m_wr) return m_reg[m_off];
    return '0;
  endfunction

  function automatic void model_step(input logic sel, input logic [1:0] trans,
                                     input logic [31:0] addr, input logic [2:0] size,
                                     input logic wr, input logic [31:0] wdata);
    logic en, tick, hit;
    int   aoff;
    en   = m_reg[0][0];
    tick = en && (m_psc == m_reg[1]);
    hit  = tick && (m_reg[3] == m_reg[2]);
    if (en) m_psc = tick ? 0 : m_psc + 1;
    if (tick) m_reg[3] = (hit && m_reg[0][1]) ? 32'd0 : m_reg[3] + 32'd1;
    if (hit) m_reg[4] = 32'd1;
    if (ph == P_DATA && m_wr) begin
      case (m_off)
        0: begin
          if (en && !wdata[0]) m_psc = 0;
          m_reg[0] = wdata & 32'h7;
        end
        1: begin
          m_reg[1] = wdata & 32'hFFFF;
          m_psc    = 0;
        end
        2: m_reg[2] = wdata;
        3: m_reg[3] = wdata;
        default: if (wdata[0] && !hit) m_reg[4] = 32'd0;
      endcase
    end
    aoff = int'(addr[4:2]);
    if (ph == P_ERR1) ph = P_ERR2;
    else if (sel && trans[1]) begin
      m_wr  = wr;
      m_off = aoff;
      ph    = (size == 3'b010 && aoff <= 4) ? P_DATA : P_ERR1;
    end else ph = P_IDLE;
  endfunction

  // One bus cycle: entered at posedge+1, outputs compared at negedge, model advanced.
  task automatic run_cycle(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                           input logic [2:0] size, input logic wr, input logic [31:0] wdata);
    hsel   = sel;
    htrans = trans;
    haddr  = addr;
    hsize  = size;
    hwrite = wr;
    hwdata = wdata;
    hburst = 3'($urandom);
    hprot  = 4'($urandom);
    @(negedge clk);
    check("hreadyout", {31'd0, hreadyout}, {31'd0, ph != P_ERR1});
    check("hresp", {31'd0, hresp}, {31'd0, (ph == P_ERR1) || (ph == P_ERR2)});
    check("hrdata", hrdata, exp_rdata());
    check("irq", {31'd0, irq}, {31'd0, m_reg[4][0] & m_reg[0][2]});
    model_step(sel, trans, addr, size, wr, wdata);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 2'b00, 32'd0, 3'b010, 1'b0, 32'd0);
  endtask

  task automatic wr_reg(input int off, input logic [31:0] d);
    run_cycle(1'b1, 2'b10, 32'(off * 4), 3'b010, 1'b1, 32'd0);
    run_cycle(1'b0, 2'b00, 32'd0, 3'b010, 1'b0, d);
  endtask

  task automatic rd_reg(input int off);
    run_cycle(1'b1, 2'b10, 32'(off * 4), 3'b010, 1'b0, 32'd0);
    idle_cycle();
  endtask

  function automatic logic [31:0] rand_wdata(input int off);
    case (off)
      0:       return $urandom;
      1:       return $urandom_range(0, 3);
      2:       return $urandom_range(0, 12);
      3:       return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : $urandom_range(0, 12);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n  = 1'b0;
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = '0;
    hsize  = 3'b010;
    hwrite = 1'b0;
    hwdata = '0;
    hburst = '0;
    hprot  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    check("rst_hresp", {31'd0, hresp}, 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) rd_reg(i);

    // Compare match six ticks after enable, then W1C.
    wr_reg(2, 32'd5);
    wr_reg(1, 32'd0);
    wr_reg(0, 32'h5);
    repeat (5) idle_cycle();
    check("irq_before_match", {31'd0, irq}, 32'd0);
    idle_cycle();
    check("irq_at_match", {31'd0, irq}, 32'd1);
    wr_reg(4, 32'd1);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);

    // Auto-reload with prescale 1.
    wr_reg(0, 32'h0);
    wr_reg(3, 32'd0);
    wr_reg(2, 32'd3);
    wr_reg(1, 32'd1);
    wr_reg(0, 32'h3);
    for (int i = 0; i < 10; i++) rd_reg(3);

    // Illegal size and out-of-range offset.
    run_cycle(1'b1, 2'b10, 32'h8, 3'b001, 1'b0, 32'd0);
    check("err1_hreadyout", {31'd0, hreadyout}, 32'd0);
    check("err1_hresp", {31'd0, hresp}, 32'd1);
    idle_cycle();
    idle_cycle();
    run_cycle(1'b1, 2'b10, 32'h14, 3'b010, 1'b0, 32'd0);
    idle_cycle();
    idle_cycle();

    // COUNT wrap-around.
    wr_reg(0, 32'h0);
    wr_reg(1, 32'd0);
    wr_reg(2, 32'd100);
    wr_reg(0, 32'h1);
    wr_reg(3, 32'hFFFF_FFFF);
    rd_reg(3);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      a  = {$urandom, 5'd0} | 32'(($urandom_range(0, 7) % 6) * 4) | 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
      run_cycle($urandom_range(0, 3) != 0, 2'($urandom), a, sz, 1'($urandom),
                (ph == P_DATA && m_wr) ? rand_wdata(m_off) : $urandom);
    end

    // Reset while the error response is in progress.
    wr_reg(2, 32'hA5A5_0001);
    run_cycle(1'b1, 2'b10, 32'h1C, 3'b010, 1'b1, 32'd0);
    hsel   = 1'b0;
    htrans = 2'b00;
    rst_n  = 1'b0;
    #1;
    check("rst_mid_hreadyout", {31'd0, hreadyout}, 32'd1);
    check("rst_mid_hresp", {31'd0, hresp}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) rd_reg(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
